// File: rtl/cs_pkg.sv
// -----------------------------------------------------------------------------
// cs_pkg
//   Definitions shared by the chip-select sequencer (cs_seq) and the
//   downstream cs_mux:
//     - bit positions inside the 5-bit cfg word {valid, bank, ch[2:0]}
//     - FSM state encodings for the sequencer
//     - make_cfg(): builds a valid cfg word from a 4-bit scan index
// -----------------------------------------------------------------------------
package cs_pkg;

  localparam int CFG_W         = 5;
  localparam int CFG_VALID_BIT = 4;
  localparam int CFG_BANK_BIT  = 3;
  localparam int CFG_CH_MSB    = 2;
  localparam int CFG_CH_LSB    = 0;

  // Scan index covers {bank, ch}: 2 banks x 8 channels.
  localparam int IDX_W  = 4;
  localparam int MASK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SEL   = 2'd2
  } state_e;

  // Index bit 3 is the bank, bits 2:0 the channel within the bank.
  function automatic logic [CFG_W-1:0] make_cfg(input logic [IDX_W-1:0] idx);
    logic [CFG_W-1:0] c;
    c                         = '0;
    c[CFG_VALID_BIT]          = 1'b1;
    c[CFG_BANK_BIT]           = idx[3];
    c[CFG_CH_MSB:CFG_CH_LSB]  = idx[2:0];
    return c;
  endfunction

endpackage

// File: rtl/cs_dwell_timer.sv
// -----------------------------------------------------------------------------
// cs_dwell_timer
//   Loadable down-counter with a terminal-count flag. Loading N makes tc_o
//   rise in the N-th cycle after the load edge (N >= 1), so a state that loads
//   N on entry and leaves when tc_o is high lasts exactly N cycles.
//   Used by cs_seq for both guard and dwell timing.
// Ports
//   aclk        in   clock, rising edge
//   aresetn     in   asynchronous active-low reset
//   load_i      in   load load_val_i this cycle (takes priority over counting)
//   load_val_i  in   W-bit load value
//   tc_o        out  high while the count equals 1 (last cycle of the period)
// -----------------------------------------------------------------------------
module cs_dwell_timer #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == W'(1));

endmodule

// File: rtl/cs_seq.sv
// -----------------------------------------------------------------------------
// cs_seq
//   Chip-select scan sequencer driving the cfg word of cs_mux.
//   On start it walks every enabled channel of bank 0 (ch0..7) and then of
//   bank 1 (ch0..7). Each selection lasts max(dwell,1) cycles and is preceded
//   by guard deselect cycles (none when guard = 0). Mask, dwell, guard (and
//   loop) are shadowed when start is accepted.
//
//   Optional feature macro: CS_SEQ_LOOP_EN
//     defined   : adds input 'loop'; when set at start, the scan wraps to the
//                 lowest enabled entry forever (no done) until stop.
//     undefined : single-shot scans only, no 'loop' port.
//
// Ports
//   aclk     in   clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   start    in   begin a scan when idle
//   stop     in   abort the scan in progress (wins over start when idle)
//   mask0    in   [7:0] bank-0 channel enables
//   mask1    in   [7:0] bank-1 channel enables
//   dwell    in   [DWELL_W-1:0] selection length, 0 treated as 1
//   guard    in   [GUARD_W-1:0] deselect cycles before each selection
//   loop     in   (CS_SEQ_LOOP_EN only) repeat the scan until stop
//   cfg      out  [4:0] {valid, bank, ch} to cs_mux, registered
//   busy     out  high while a scan is running, registered
//   done     out  1-cycle pulse at normal end of scan, registered
// -----------------------------------------------------------------------------
module cs_seq
  import cs_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int GUARD_W = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask0,
  input  logic [7:0]         mask1,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [GUARD_W-1:0] guard,
`ifdef CS_SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [CFG_W-1:0]   cfg,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MASK_W-1:0]  mask_s_q, mask_s_d;
  logic [DWELL_W-1:0] dwell_s_q, dwell_s_d;
  logic [GUARD_W-1:0] guard_s_q, guard_s_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               idle;
  logic               accept;
  logic [MASK_W-1:0]  cur_mask;
  logic [DWELL_W-1:0] cur_dwell;
  logic [GUARD_W-1:0] cur_guard;
  logic               cur_loop;
  logic [DWELL_W-1:0] dwell_ld;
  logic [DWELL_W-1:0] guard_ld;

  logic               first_vld, next_vld;
  logic [IDX_W-1:0]   first_idx, next_idx;

  logic               enter;
  logic [IDX_W-1:0]   enter_idx;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_val;
  logic               tmr_tc;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && start && !stop;

  // In the accepting cycle the live inputs decide the first step; afterwards
  // only the shadow copies are used, so mid-scan input changes are invisible.
  assign cur_mask  = idle ? {mask1, mask0} : mask_s_q;
  assign cur_dwell = idle ? dwell : dwell_s_q;
  assign cur_guard = idle ? guard : guard_s_q;

  assign dwell_ld = (cur_dwell == '0) ? DWELL_W'(1) : cur_dwell;
  assign guard_ld = DWELL_W'(cur_guard);

`ifdef CS_SEQ_LOOP_EN
  logic loop_s_q;

  assign cur_loop = idle ? loop : loop_s_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      loop_s_q <= 1'b0;
    end else if (accept) begin
      loop_s_q <= loop;
    end
  end
`else
  assign cur_loop = 1'b0;
`endif

  // Priority encoders: lowest enabled entry overall, and lowest enabled entry
  // strictly above the current index. Scanning downward lets the last hit win.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (cur_mask[i]) begin
        first_vld = 1'b1;
        first_idx = IDX_W'(i);
        if (IDX_W'(i) > idx_q) begin
          next_vld = 1'b1;
          next_idx = IDX_W'(i);
        end
      end
    end
  end

  cs_dwell_timer #(
    .W (DWELL_W)
  ) u_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_s_d  = mask_s_q;
    dwell_s_d = dwell_s_q;
    guard_s_d = guard_s_q;
    tmr_load  = 1'b0;
    tmr_val   = dwell_ld;
    done_d    = 1'b0;
    enter     = 1'b0;
    enter_idx = idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mask_s_d  = {mask1, mask0};
          dwell_s_d = dwell;
          guard_s_d = guard;
          if (first_vld) begin
            enter     = 1'b1;
            enter_idx = first_idx;
          end else begin
            // Empty mask: finish at once without ever raising busy.
            done_d = 1'b1;
          end
        end
      end

      ST_GUARD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          state_d  = ST_SEL;
          tmr_load = 1'b1;
          tmr_val  = dwell_ld;
        end
      end

      ST_SEL: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tmr_tc) begin
          if (next_vld) begin
            enter     = 1'b1;
            enter_idx = next_idx;
          end else if (cur_loop && first_vld) begin
            enter     = 1'b1;
            enter_idx = first_idx;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Start of a new selection: through GUARD when guard cycles are
    // configured, otherwise straight into SEL.
    if (enter) begin
      idx_d    = enter_idx;
      tmr_load = 1'b1;
      if (cur_guard != '0) begin
        state_d = ST_GUARD;
        tmr_val = guard_ld;
      end else begin
        state_d = ST_SEL;
        tmr_val = dwell_ld;
      end
    end

    // Outputs are derived from the next state so they register alongside it.
    busy_d = (state_d != ST_IDLE);
    cfg_d  = (state_d == ST_SEL) ? make_cfg(idx_d) : '0;
  end

  // Shadow registers are cleared on reset too, so a scan aborted by reset
  // leaves no stale configuration behind.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mask_s_q  <= '0;
      dwell_s_q <= '0;
      guard_s_q <= '0;
      cfg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_s_q  <= mask_s_d;
      dwell_s_q <= dwell_s_d;
      guard_s_q <= guard_s_d;
      cfg_q     <= cfg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cfg  = cfg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
